// File: rtl/image_stream_driver_if.sv
// Host-side and core-side signal bundle of the image stream driver.
// The driver connects through the slave modport and its environment through the master modport.
interface image_stream_driver_if;
  logic [7:0] host_data;
  logic       host_valid;
  logic       host_ready;
  logic       wb_load;
  logic       net_rst_n;
  logic [7:0] pix_data;
  logic       pix_active;
  logic [3:0] decision_in;
  logic       decision_valid;
  logic [3:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       timeout_err;
  logic       busy;

  modport slave (
    input  host_data, host_valid, decision_in, decision_valid, result_ready,
    output host_ready, wb_load, net_rst_n, pix_data, pix_active,
           result, result_valid, timeout_err, busy
  );

  modport master (
    output host_data, host_valid, decision_in, decision_valid, result_ready,
    input  host_ready, wb_load, net_rst_n, pix_data, pix_active,
           result, result_valid, timeout_err, busy
  );
endinterface

// File: rtl/image_stream_driver.sv
// Buffers one host image, loads the core weights once, resets the core pipeline,
// streams the pixels into the core and hands the core's decision back to the host.
module image_stream_driver #(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int ADDR_BIT    = 10,
  parameter int WB_WAIT     = 2,
  parameter int NET_RST_CYC = 4,
  parameter int TIMEOUT     = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  image_stream_driver_if.slave  bus
);

  localparam int N     = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(N - 1);
  localparam logic [CNT_W-1:0]    WB_LAST   = CNT_W'(WB_WAIT - 1);
  localparam logic [CNT_W-1:0]    NR_LAST   = CNT_W'(NET_RST_CYC - 1);
  localparam logic [CNT_W-1:0]    TO_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_WB_PULSE = 4'd1,
    ST_WB_HOLD  = 4'd2,
    ST_FILL     = 4'd3,
    ST_NET_RST  = 4'd4,
    ST_STREAM   = 4'd5,
    ST_DRAIN    = 4'd6,
    ST_WAIT_DEC = 4'd7,
    ST_RESULT   = 4'd8
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic [ADDR_BIT-1:0] wr_addr_r;
  logic [ADDR_BIT-1:0] wr_addr_nxt_s;
  logic [ADDR_BIT-1:0] rd_addr_r;
  logic [ADDR_BIT-1:0] rd_addr_nxt_s;
  logic                accept_s;
  logic [3:0]          result_nxt_s;
  logic                timeout_err_nxt_s;

  logic [7:0]          pix_mem [0:N-1];
  logic [7:0]          rd_data_r;
  logic                rd_valid_r;

  logic                wb_load_r;
  logic                host_ready_r;
  logic                net_rst_n_r;
  logic [7:0]          pix_data_r;
  logic                pix_active_r;
  logic [3:0]          result_r;
  logic                result_valid_r;
  logic                timeout_err_r;
  logic                busy_r;

  // host_ready_r is only ever high in FILL, so this also gates writes to FILL
  assign accept_s = bus.host_valid & host_ready_r;

  // Next-state, address, counter and capture logic
  always_comb begin
    state_nxt_s       = state_r;
    wr_addr_nxt_s     = wr_addr_r;
    rd_addr_nxt_s     = rd_addr_r;
    result_nxt_s      = result_r;
    timeout_err_nxt_s = timeout_err_r;

    case (state_r)
      ST_INIT: begin
        state_nxt_s = ST_WB_PULSE;
      end
      ST_WB_PULSE: begin
        state_nxt_s = ST_WB_HOLD;
      end
      ST_WB_HOLD: begin
        if (cnt_r == WB_LAST) begin
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_WB_HOLD;
        end
      end
      ST_FILL: begin
        if (accept_s) begin
          if (wr_addr_r == LAST_ADDR) begin
            wr_addr_nxt_s = {ADDR_BIT{1'b0}};
            state_nxt_s   = ST_NET_RST;
          end else begin
            wr_addr_nxt_s = wr_addr_r + ADDR_BIT'(1);
          end
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_NET_RST: begin
        if (cnt_r == NR_LAST) begin
          state_nxt_s = ST_STREAM;
        end else begin
          state_nxt_s = ST_NET_RST;
        end
      end
      ST_STREAM: begin
        if (rd_addr_r == LAST_ADDR) begin
          rd_addr_nxt_s = {ADDR_BIT{1'b0}};
          state_nxt_s   = ST_DRAIN;
        end else begin
          rd_addr_nxt_s = rd_addr_r + ADDR_BIT'(1);
        end
      end
      ST_DRAIN: begin
        state_nxt_s = ST_WAIT_DEC;
      end
      ST_WAIT_DEC: begin
        // A real decision wins over a timeout expiring in the same cycle
        if (bus.decision_valid) begin
          result_nxt_s = bus.decision_in;
          state_nxt_s  = ST_RESULT;
        end else if (cnt_r == TO_LAST) begin
          result_nxt_s      = 4'hF;
          timeout_err_nxt_s = 1'b1;
          state_nxt_s       = ST_RESULT;
        end else begin
          state_nxt_s = ST_WAIT_DEC;
        end
      end
      ST_RESULT: begin
        if (bus.result_ready) begin
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_RESULT;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase

    if ((state_nxt_s == state_r) &&
        ((state_r == ST_WB_HOLD) || (state_r == ST_NET_RST) || (state_r == ST_WAIT_DEC))) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // State, counters and registered outputs; outputs decode the next state so they change with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_INIT;
      cnt_r          <= {CNT_W{1'b0}};
      wr_addr_r      <= {ADDR_BIT{1'b0}};
      rd_addr_r      <= {ADDR_BIT{1'b0}};
      rd_valid_r     <= 1'b0;
      wb_load_r      <= 1'b0;
      host_ready_r   <= 1'b0;
      net_rst_n_r    <= 1'b1;
      pix_data_r     <= 8'd0;
      pix_active_r   <= 1'b0;
      result_r       <= 4'd0;
      result_valid_r <= 1'b0;
      timeout_err_r  <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      wr_addr_r      <= wr_addr_nxt_s;
      rd_addr_r      <= rd_addr_nxt_s;
      rd_valid_r     <= (state_r == ST_STREAM);
      wb_load_r      <= (state_nxt_s == ST_WB_PULSE);
      host_ready_r   <= (state_nxt_s == ST_FILL);
      net_rst_n_r    <= (state_nxt_s != ST_NET_RST);
      pix_active_r   <= rd_valid_r;
      pix_data_r     <= rd_valid_r ? rd_data_r : 8'd0;
      result_r       <= result_nxt_s;
      result_valid_r <= (state_nxt_s == ST_RESULT);
      timeout_err_r  <= timeout_err_nxt_s;
      busy_r         <= (state_nxt_s != ST_FILL);
    end
  end

  // Image buffer: host write port plus a synchronous read port for streaming
  always_ff @(posedge clk) begin
    if (accept_s) begin
      pix_mem[wr_addr_r] <= bus.host_data;
    end
    rd_data_r <= pix_mem[rd_addr_r];
  end

  assign bus.host_ready   = host_ready_r;
  assign bus.wb_load      = wb_load_r;
  assign bus.net_rst_n    = net_rst_n_r;
  assign bus.pix_data     = pix_data_r;
  assign bus.pix_active   = pix_active_r;
  assign bus.result       = result_r;
  assign bus.result_valid = result_valid_r;
  assign bus.timeout_err  = timeout_err_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_image_stream_driver.sv
// Directed bench for image_stream_driver: startup vector table plus hand-written
// sequences for fill, streaming, decision handshake, timeout and mid-stream reset.
module tb_image_stream_driver;

  localparam int N           = 784;
  localparam int NET_RST_CYC = 4;
  localparam int TIMEOUT     = 4096;

  typedef struct {
    int   cyc;
    logic hv;
    logic wb;
    logic hr;
    logic bz;
    logic nr;
  } su_vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   wb_cnt = 0;
  su_vec_t su_tab [6];

  image_stream_driver_if bus ();

  image_stream_driver #(
    .IMG_W(28), .IMG_H(28), .ADDR_BIT(10),
    .WB_WAIT(2), .NET_RST_CYC(NET_RST_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wb_load === 1'b1) wb_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not reach its end within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] outs();
    return {bus.wb_load, bus.host_ready, bus.net_rst_n, bus.pix_data, bus.pix_active,
            bus.result, bus.result_valid, bus.timeout_err, bus.busy};
  endfunction

  // Called at the sample right after rst_n release
  task automatic run_startup();
    int cur = 0;
    for (int i = 0; i < 6; i++) begin
      while (cur < su_tab[i].cyc) begin
        tick();
        cur++;
      end
      check($sformatf("su%0d_wb_load", i),    32'(bus.wb_load),    32'(su_tab[i].wb));
      check($sformatf("su%0d_host_ready", i), 32'(bus.host_ready), 32'(su_tab[i].hr));
      check($sformatf("su%0d_busy", i),       32'(bus.busy),       32'(su_tab[i].bz));
      check($sformatf("su%0d_net_rst_n", i),  32'(bus.net_rst_n),  32'(su_tab[i].nr));
      bus.host_valid = su_tab[i].hv;
      bus.host_data  = 8'h55;
    end
  endtask

  task automatic feed(input int toggle, input int base);
    int i = 0;
    int cycles = 0;
    logic v;
    logic acc;
    while (i < N && cycles < 4 * N) begin
      v = (toggle == 0) ? 1'b1 : ((cycles % 2) == 1);
      bus.host_valid = v;
      bus.host_data  = 8'(base + i);
      acc = v && bus.host_ready;
      tick();
      cycles++;
      if (acc) i++;
    end
    check("fill_cycles", 32'(cycles), (toggle == 0) ? 32'(N) : 32'(2 * N));
    check("fill_ready_drop", 32'(bus.host_ready), 32'd0);
    // host keeps offering junk while the driver is busy
    bus.host_valid = 1'b1;
    bus.host_data  = 8'hEE;
  endtask

  task automatic stream_check(input int base, input int abort_k);
    int lowc = 0;
    int g = 0;
    int bad = 0;
    bit aborted = 1'b0;
    logic [7:0] e;
    while (bus.net_rst_n !== 1'b1 && g < 100) begin
      lowc++;
      tick();
      g++;
    end
    check("netrst_low_cycles", 32'(lowc), 32'(NET_RST_CYC));
    tick();
    check("pre_window_idle", 32'({bus.pix_active, bus.pix_data}), 32'd0);
    bus.result_ready = 1'b1;
    tick();
    for (int k = 0; k < N; k++) begin
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check("abort_reset_outputs", 32'(outs()), 32'h10000);
        aborted = 1'b1;
        break;
      end
      bus.decision_valid = (k == 100) || (k == N - 2);
      bus.decision_in    = 4'h3;
      e = 8'(base + k);
      if (bus.pix_active !== 1'b1 || bus.pix_data !== e) bad++;
      tick();
    end
    bus.decision_valid = 1'b0;
    bus.decision_in    = 4'h0;
    bus.result_ready   = 1'b0;
    bus.host_valid     = 1'b0;
    if (!aborted) begin
      check("stream_pixels_bad", 32'(bad), 32'd0);
      check("post_window_idle", 32'({bus.pix_active, bus.pix_data}), 32'd0);
    end
  endtask

  task automatic do_decision(input logic [3:0] d, input int delay, input int hold);
    int rv_cnt = 0;
    int unstable = 0;
    repeat (delay) tick();
    bus.decision_in    = d;
    bus.decision_valid = 1'b1;
    tick();
    bus.decision_valid = 1'b0;
    bus.decision_in    = 4'h0;
    check("dec_result", 32'(bus.result), 32'(d));
    check("dec_valid_rise", 32'(bus.result_valid), 32'd1);
    for (int j = 0; j <= hold; j++) begin
      if (bus.result_valid === 1'b1) rv_cnt++;
      if (bus.result !== d) unstable++;
      bus.result_ready = (j == hold);
      tick();
    end
    bus.result_ready = 1'b0;
    check("dec_valid_len", 32'(rv_cnt), 32'(hold + 1));
    check("dec_hold_stable", 32'(unstable), 32'd0);
    check("dec_valid_drop", 32'(bus.result_valid), 32'd0);
    check("dec_host_ready", 32'(bus.host_ready), 32'd1);
  endtask

  initial begin
    int t;
    su_tab[0] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    su_tab[1] = '{1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    su_tab[2] = '{2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    su_tab[3] = '{3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    su_tab[4] = '{4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    su_tab[5] = '{5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst_n              = 1'b0;
    bus.host_data      = 8'h00;
    bus.host_valid     = 1'b0;
    bus.decision_in    = 4'h0;
    bus.decision_valid = 1'b0;
    bus.result_ready   = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'(outs()), 32'h10000);
    rst_n = 1'b1;
    run_startup();

    // image 1: continuous fill, decision after a delay, slow host read
    feed(0, 0);
    stream_check(0, -1);
    do_decision(4'd7, 48, 10);
    check("no_timeout_yet", 32'(bus.timeout_err), 32'd0);

    // image 2: no decision at all
    feed(0, 37);
    stream_check(37, -1);
    check("timeout_clear_before", 32'(bus.timeout_err), 32'd0);
    t = 0;
    while (bus.result_valid !== 1'b1 && t < TIMEOUT + 100) begin
      tick();
      t++;
    end
    check("timeout_wait_cycles", 32'(t + 1), 32'(TIMEOUT));
    check("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    check("timeout_result", 32'(bus.result), 32'hF);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("one_cycle_result_drop", 32'(bus.result_valid), 32'd0);
    check("one_cycle_host_ready", 32'(bus.host_ready), 32'd1);

    // image 3: stalled fill, same content; timeout flag stays set
    feed(1, 0);
    stream_check(0, -1);
    check("timeout_sticky", 32'(bus.timeout_err), 32'd1);
    do_decision(4'h2, 3, 0);

    // image 4: reset lands at pixel 300
    feed(0, 200);
    stream_check(200, 300);
    repeat (2) tick();
    rst_n = 1'b1;
    run_startup();

    // image 5: fill restarts from address 0
    feed(0, 99);
    stream_check(99, -1);
    do_decision(4'hA, 0, 2);
    check("after_reset_timeout_clear", 32'(bus.timeout_err), 32'd0);
    check("wb_load_pulse_cycles", 32'(wb_cnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
